// File: rtl/key_debounce_multi_if.sv
// Button bundle between raw key inputs and debounced event outputs.
// `release` and `repeat` are language keywords, so those outputs are named key_release / key_repeat.
interface key_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] butt;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] key_release;
    logic [N_CH-1:0] long_press;
    logic [N_CH-1:0] key_repeat;
    logic            any_press;

    modport master (
        output butt,
        input  level, press, key_release, long_press, key_repeat, any_press
    );

    modport slave (
        input  butt,
        output level, press, key_release, long_press, key_repeat, any_press
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press/release pulses, long-press detection and auto-repeat.
// Each channel: 2-flop synchroniser, debounce counter, and an IDLE/HOLD/REPEAT hold FSM.
module key_debounce_multi #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 20,
    parameter int DB_CYCLES     = 100000,
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 200000,
    parameter int ACTIVE_HIGH   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  bus
);
    localparam int HW = CNT_W + 4;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [HW-1:0]    LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0]    REP_LAST  = HW'(REPEAT_CYCLES - 1);
    localparam bit               REP_EN    = (REPEAT_CYCLES != 0);
    // Raw value of a released button, loaded into the synchroniser on reset.
    localparam logic [N_CH-1:0]  RAW_IDLE  = (ACTIVE_HIGH != 0) ? '0 : '1;

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    logic [N_CH-1:0] sync1, sync2, s;
    logic [N_CH-1:0] level_r, press_r, rel_r, long_r, rpt_r;
    logic            any_r;
    logic [N_CH-1:0] level_nxt, press_nxt, rel_nxt, long_nxt, rpt_nxt;
    logic [CNT_W-1:0] db_cnt   [N_CH];
    logic [CNT_W-1:0] db_nxt   [N_CH];
    logic [HW-1:0]    hold_cnt [N_CH];
    logic [HW-1:0]    hold_nxt [N_CH];
    state_t           state     [N_CH];
    state_t           state_nxt [N_CH];

    assign s = (ACTIVE_HIGH != 0) ? sync2 : ~sync2;

    always_comb begin
        level_nxt = level_r;
        press_nxt = '0;
        rel_nxt   = '0;
        long_nxt  = '0;
        rpt_nxt   = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_nxt[i]    = '0;
            hold_nxt[i]  = hold_cnt[i];
            state_nxt[i] = state[i];

            // A mismatch lasting DB_CYCLES consecutive cycles is accepted; any match restarts.
            if (s[i] != level_r[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    level_nxt[i] = ~level_r[i];
                    press_nxt[i] = ~level_r[i];
                    rel_nxt[i]   = level_r[i];
                end else begin
                    db_nxt[i] = db_cnt[i] + 1'b1;
                end
            end

            if (rel_nxt[i]) begin
                state_nxt[i] = IDLE;
                hold_nxt[i]  = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        hold_nxt[i] = '0;
                        if (press_nxt[i]) state_nxt[i] = HOLD;
                    end
                    HOLD: begin
                        if (hold_cnt[i] == LONG_LAST) begin
                            long_nxt[i]  = 1'b1;
                            hold_nxt[i]  = '0;
                            state_nxt[i] = RPT;
                        end else begin
                            hold_nxt[i] = hold_cnt[i] + 1'b1;
                        end
                    end
                    RPT: begin
                        if (REP_EN) begin
                            if (hold_cnt[i] == REP_LAST) begin
                                rpt_nxt[i]  = 1'b1;
                                hold_nxt[i] = '0;
                            end else begin
                                hold_nxt[i] = hold_cnt[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_nxt[i] = IDLE;
                        hold_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= RAW_IDLE;
            sync2   <= RAW_IDLE;
            level_r <= '0;
            press_r <= '0;
            rel_r   <= '0;
            long_r  <= '0;
            rpt_r   <= '0;
            any_r   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
                state[i]    <= IDLE;
            end
        end else begin
            sync1   <= bus.butt;
            sync2   <= sync1;
            level_r <= level_nxt;
            press_r <= press_nxt;
            rel_r   <= rel_nxt;
            long_r  <= long_nxt;
            rpt_r   <= rpt_nxt;
            any_r   <= |press_r;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i]   <= db_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
                state[i]    <= state_nxt[i];
            end
        end
    end

    assign bus.level       = level_r;
    assign bus.press       = press_r;
    assign bus.key_release = rel_r;
    assign bus.long_press  = long_r;
    assign bus.key_repeat  = rpt_r;
    assign bus.any_press   = any_r;
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: an active-high and an active-low instance share one pressed-state
// stimulus and are compared each cycle against a run-length/hold-time reference model.
module tb_key_debounce_multi;
    localparam int NC   = 2;
    localparam int DB   = 4;
    localparam int LONG = 10;
    localparam int REP  = 3;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] p;

    key_debounce_multi_if #(.N_CH(NC)) ifh ();
    key_debounce_multi_if #(.N_CH(NC)) ifl ();

    assign ifh.butt = p;
    assign ifl.butt = ~p;

    key_debounce_multi #(.N_CH(NC), .CNT_W(8), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
                         .REPEAT_CYCLES(REP), .ACTIVE_HIGH(1))
        dut_h (.clk(clk), .rst_n(rst_n), .bus(ifh));
    key_debounce_multi #(.N_CH(NC), .CNT_W(8), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
                         .REPEAT_CYCLES(REP), .ACTIVE_HIGH(0))
        dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, all in pressed-domain (1 = pressed).
    bit          sy1 [NC];
    bit          sy2 [NC];
    bit          lvl [NC];
    int          run [NC];
    int          held[NC];
    logic [NC-1:0] e_press, e_rel, e_long, e_rpt, e_lvl;
    logic          e_any;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                sy1[c] = 0; sy2[c] = 0; lvl[c] = 0; run[c] = 0; held[c] = -1;
            end
            e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0; e_lvl = '0; e_any = 1'b0;
            return;
        end
        e_any = |e_press;
        for (int c = 0; c < NC; c++) begin
            bit acc;
            acc = 0;
            e_press[c] = 0; e_rel[c] = 0; e_long[c] = 0; e_rpt[c] = 0;
            if (sy2[c] != lvl[c]) begin
                run[c]++;
                if (run[c] == DB) begin acc = 1; run[c] = 0; end
            end else begin
                run[c] = 0;
            end
            if (acc) begin
                lvl[c] = !lvl[c];
                if (lvl[c]) begin e_press[c] = 1; held[c] = 0; end
                else begin e_rel[c] = 1; held[c] = -1; end
            end else if (held[c] >= 0) begin
                held[c]++;
                e_long[c] = (held[c] == LONG);
                e_rpt[c]  = (REP != 0) && (held[c] > LONG) && ((held[c] - LONG) % REP == 0);
            end
            e_lvl[c] = lvl[c];
            sy2[c] = sy1[c];
            sy1[c] = p[c];
        end
    endfunction

    task automatic compare_all();
        check("level_h",   16'(ifh.level),       16'(e_lvl));
        check("press_h",   16'(ifh.press),       16'(e_press));
        check("release_h", 16'(ifh.key_release), 16'(e_rel));
        check("long_h",    16'(ifh.long_press),  16'(e_long));
        check("repeat_h",  16'(ifh.key_repeat),  16'(e_rpt));
        check("any_h",     16'(ifh.any_press),   16'(e_any));
        check("level_l",   16'(ifl.level),       16'(e_lvl));
        check("press_l",   16'(ifl.press),       16'(e_press));
        check("release_l", 16'(ifl.key_release), 16'(e_rel));
        check("long_l",    16'(ifl.long_press),  16'(e_long));
        check("repeat_l",  16'(ifl.key_repeat),  16'(e_rpt));
        check("any_l",     16'(ifl.any_press),   16'(e_any));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int n_press, n_rel, n_rpt, k_press, k_long, k_rpt1, hold_len;
    bit seen_rel;

    initial begin
        rst_n = 1'b0;
        p     = '0;
        for (int c = 0; c < NC; c++) held[c] = -1;
        repeat (3) tick();
        check("reset_level", 16'(ifh.level), 16'h0);
        check("reset_any",   16'(ifh.any_press), 16'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean press on channel 0: accepted on the 5th edge after first sampling.
        p = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("dir_press_early", 16'(ifh.press), 16'h0);
        end
        tick();
        check("dir_press_edge", 16'(ifh.press), 16'h1);
        check("dir_level_edge", 16'(ifl.level), 16'h1);
        tick();
        check("dir_any_next", 16'(ifh.any_press), 16'h1);
        repeat (3) tick();
        p = 2'b00;
        repeat (20) tick();

        // Short pulse is rejected, then a bounce yields exactly one press.
        n_press = 0;
        p = 2'b01;
        repeat (3) begin tick(); n_press += ifh.press[0]; end
        p = 2'b00;
        repeat (8) begin tick(); n_press += ifh.press[0]; end
        check("dir_glitch_press", 16'(n_press), 16'd0);
        check("dir_glitch_level", 16'(ifh.level), 16'h0);
        n_press = 0;
        p = 2'b01; tick(); n_press += ifh.press[0];
        p = 2'b00; tick(); n_press += ifh.press[0];
        p = 2'b01;
        repeat (12) begin tick(); n_press += ifh.press[0]; end
        check("dir_bounce_press", 16'(n_press), 16'd1);
        p = 2'b00;
        repeat (20) tick();

        // Long hold on channel 1: long_press 10 after press, repeats every 3.
        k_press = -1; k_long = -1; k_rpt1 = -1;
        p = 2'b10;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ifh.press[1] && k_press < 0) k_press = k;
            if (ifh.long_press[1] && k_long < 0) k_long = k;
            if (ifh.key_repeat[1] && k_rpt1 < 0) k_rpt1 = k;
        end
        check("dir_long_delay", 16'(k_long - k_press), 16'd10);
        check("dir_rpt_delay",  16'(k_rpt1 - k_long), 16'd3);
        p = 2'b00;
        n_rel = 0; n_rpt = 0; seen_rel = 0;
        repeat (20) begin
            tick();
            if (seen_rel) n_rpt += ifh.key_repeat[1];
            if (ifh.key_release[1]) begin n_rel++; seen_rel = 1; end
        end
        check("dir_release_once", 16'(n_rel), 16'd1);
        check("dir_no_rpt_after", 16'(n_rpt), 16'd0);

        // Simultaneous press on both channels.
        n_press = 0;
        p = 2'b11;
        repeat (8) begin
            tick();
            if (ifh.press == 2'b11) n_press++;
        end
        check("dir_both_press", 16'(n_press), 16'd1);
        p = 2'b00;
        repeat (20) tick();

        // Reset while in repeat, then re-debounce of a still-held key.
        p = 2'b01;
        repeat (22) tick();
        rst_n = 1'b0;
        tick();
        check("dir_rst_press", 16'(ifh.press), 16'h0);
        check("dir_rst_level", 16'(ifh.level), 16'h0);
        check("dir_rst_rpt",   16'(ifh.key_repeat), 16'h0);
        rst_n = 1'b1;
        k_press = -1; k_long = -1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (ifh.press[0] && k_press < 0) k_press = k;
            if (ifh.long_press[0] && k_long < 0) k_long = k;
        end
        check("dir_rst_repress", 16'(k_press), 16'd5);
        check("dir_rst_long",    16'(k_long - k_press), 16'd10);
        p = 2'b00;
        repeat (20) tick();

        // Randomised holds, bounces and occasional resets.
        for (int n = 0; n < 300; n++) begin
            p        = NC'($urandom_range(0, 3));
            rst_n    = ($urandom_range(0, 40) != 0);
            hold_len = $urandom_range(1, 20);
            repeat (hold_len) tick();
            rst_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 Parameter: N_CH, 4, number of independent button channels (1..16).
REQ-002 Parameter: CNT_W, 20, width of the debounce and hold counters.
REQ-003 Parameter: DB_CYCLES, 100000, stable cycles required to accept a level change (2..2^CNT_W-1).
REQ-004 Parameter: LONG_CYCLES, 1000000, held cycles after an accepted press before long_press fires; must fit CNT_W+4 bits.
REQ-005 Parameter: REPEAT_CYCLES, 200000, auto-repeat period after long_press; 0 disables repeat.
REQ-006 Parameter: ACTIVE_HIGH, 1, input polarity; 0 means a pressed button reads 0.
REQ-007 Port: clk  input  1  clock; all logic is on the rising edge.
REQ-008 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-009 Port: butt  input  N_CH  raw asynchronous button inputs.
REQ-010 Port: level  output  N_CH  debounced pressed state, 1 = pressed.
REQ-011 Port: press  output  N_CH  one-cycle pulse on an accepted press.
REQ-012 Port: release  output  N_CH  one-cycle pulse on an accepted release.
REQ-013 Port: long_press  output  N_CH  one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-014 Port: repeat  output  N_CH  one-cycle pulse every REPEAT_CYCLES after long_press while held.
REQ-015 Port: any_press  output  1  registered OR of press.

Function
REQ-016 Each channel SHALL pass butt through a 2-flop synchroniser, then invert it when ACTIVE_HIGH=0, giving s[i].
REQ-017 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-018 Debounce: while s[i]==level[i], the debounce counter SHALL hold 0.
REQ-019 While s[i]!=level[i], the counter SHALL increment by 1 per cycle.
REQ-020 When the counter equals DB_CYCLES-1 and s[i]!=level[i], the channel SHALL on that edge toggle level[i], pulse press[i] (new level 1) or release[i] (new level 0), and clear the counter.
REQ-021 Any cycle with s[i]==level[i] before acceptance (glitch) SHALL clear the counter; no pulse SHALL be produced.
REQ-022 Latency: with a constant new input from clock edge E, level/press SHALL change on edge E+2+DB_CYCLES-1.
REQ-023 Hold FSM per channel: states IDLE, HOLD, REPEAT.
REQ-024 IDLE->HOLD on an accepted press; hold counter SHALL be 0 in the cycle press is high.
REQ-025 In HOLD the hold counter SHALL increment each cycle; on reaching LONG_CYCLES-1, pulse long_press[i], clear the counter, and go to REPEAT (or stay in REPEAT with repeat disabled if REPEAT_CYCLES=0).
REQ-026 In REPEAT, when REPEAT_CYCLES!=0, the counter SHALL count; on reaching REPEAT_CYCLES-1, pulse repeat[i] and clear the counter, indefinitely.
REQ-027 An accepted release SHALL return the FSM from any state to IDLE and clear the counter in the same edge; no long_press or repeat SHALL fire on that edge.
REQ-028 press, release, long_press, repeat and any_press SHALL be high for exactly one cycle per event; press and release of one channel SHALL never both be high.
REQ-029 Counters SHALL never wrap; all compares SHALL be exact-equality against the parameter minus 1.

Reset
REQ-030 With rst_n=0 at a clock edge, all outputs SHALL be 0, the synchronisers SHALL load the released value, all counters SHALL be 0, and all FSMs SHALL be IDLE.
REQ-031 Reset asserted mid-count or mid-hold SHALL abort with no pulse; after release of reset, a button still held SHALL be re-debounced and produce a fresh press.
REQ-032 Power-up initial values SHALL equal the reset values.

Verification (N_CH=2, DB_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_HIGH=1)
REQ-033 butt[0] 0->1 held -> press[0] and level[0]=1 exactly 5 edges after the first sampling edge; any_press high in the following cycle.
REQ-034 butt[0] high for 3 cycles then low -> no press, level stays 0; a later bounce 1,0,1,1,1,1 -> exactly one press.
REQ-035 butt[1] held 30 cycles -> long_press[1] 10 cycles after press, then repeat[1] every 3 cycles; on release -> one release pulse and no further repeats.
REQ-036 Both channels pressed on the same edge -> press=2'b11 in one cycle, any_press=1 once.
REQ-037 rst_n low for 1 cycle while butt[0] is held in REPEAT -> all outputs 0, then a new press after 5 edges and long_press after 10 more.
REQ-038 ACTIVE_HIGH=0, butt idle at 1, drive 0 -> press and level=1 with the same timing as REQ-033.
